// File: rtl/ppu_timing_pkg.sv
// ---------------------------------------------------------------------------
// ppu_timing_pkg
//
// Shared definitions for the PPU raster timing core.
//   - Timing constant sets for NTSC (2C02) and PAL (2C07) parts.
//   - Bit positions of every HPLA / VPLA decode output.
//   - Dot and scanline numbers at which the decode events fire. These are
//     NTSC values and are used unchanged for every parameterisation.
//   - A small inclusive range-compare helper used by the decoders.
// ---------------------------------------------------------------------------
package ppu_timing_pkg;

    // Which family of timing constants a design instance is built for
    typedef enum logic {
        STD_NTSC = 1'b0,
        STD_PAL  = 1'b1
    } video_std_e;

    // NTSC timing set
    localparam int NTSC_CLK_DIV = 4;
    localparam int NTSC_H_LAST  = 340;
    localparam int NTSC_V_LAST  = 261;

    // PAL timing set
    localparam int PAL_CLK_DIV  = 5;
    localparam int PAL_H_LAST   = 340;
    localparam int PAL_V_LAST   = 311;

    localparam int HPLA_W = 24;
    localparam int VPLA_W = 10;

    // HPLA bit positions
    localparam int HPLA_H279         = 0;
    localparam int HPLA_H256         = 1;
    localparam int HPLA_H65          = 2;
    localparam int HPLA_FETCH_BG     = 3;
    localparam int HPLA_FETCH_0_63   = 4;
    localparam int HPLA_FETCH_64_255 = 5;
    localparam int HPLA_FETCH_SPR    = 6;
    localparam int HPLA_FETCH_PRE    = 7;
    localparam int HPLA_DUMMY        = 8;
    localparam int HPLA_H63          = 9;
    localparam int HPLA_H255         = 10;
    localparam int HPLA_H339         = 11;
    localparam int HPLA_BURST_START  = 12;
    localparam int HPLA_BURST_END    = 13;
    localparam int HPLA_H0_7         = 14;
    localparam int HPLA_H8_255       = 15;
    localparam int HPLA_TILE_STROBE  = 16;
    localparam int HPLA_H320         = 17;
    localparam int HPLA_H328         = 18;
    localparam int HPLA_FPORCH_END   = 19;
    localparam int HPLA_HSYNC        = 20;
    localparam int HPLA_HBLANK       = 21;
    localparam int HPLA_H0           = 22;
    localparam int HPLA_H340         = 23;

    // VPLA bit positions
    localparam int VPLA_V240         = 0;
    localparam int VPLA_VBL_SET      = 1;
    localparam int VPLA_VLAST        = 2;
    localparam int VPLA_VISIBLE      = 3;
    localparam int VPLA_VSYNC_START  = 4;
    localparam int VPLA_VSYNC_END    = 5;
    localparam int VPLA_V0           = 6;
    localparam int VPLA_VLAST_VB     = 7;
    localparam int VPLA_VBLANK       = 8;
    localparam int VPLA_VBL_VB       = 9;

    // Horizontal decode event dots
    localparam logic [8:0] H_0           = 9'd0;
    localparam logic [8:0] H_7           = 9'd7;
    localparam logic [8:0] H_8           = 9'd8;
    localparam logic [8:0] H_63          = 9'd63;
    localparam logic [8:0] H_64          = 9'd64;
    localparam logic [8:0] H_65          = 9'd65;
    localparam logic [8:0] H_255         = 9'd255;
    localparam logic [8:0] H_256         = 9'd256;
    localparam logic [8:0] H_FPORCH_END  = 9'd270;
    localparam logic [8:0] H_279         = 9'd279;
    localparam logic [8:0] H_HSYNC_END   = 9'd303;
    localparam logic [8:0] H_BURST_START = 9'd309;
    localparam logic [8:0] H_319         = 9'd319;
    localparam logic [8:0] H_320         = 9'd320;
    localparam logic [8:0] H_BURST_END   = 9'd324;
    localparam logic [8:0] H_328         = 9'd328;
    localparam logic [8:0] H_335         = 9'd335;
    localparam logic [8:0] H_336         = 9'd336;
    localparam logic [8:0] H_339         = 9'd339;
    localparam logic [8:0] H_340         = 9'd340;

    // Vertical decode event lines
    localparam logic [8:0] V_0           = 9'd0;
    localparam logic [8:0] V_239         = 9'd239;
    localparam logic [8:0] V_240         = 9'd240;
    localparam logic [8:0] V_VBL_SET     = 9'd241;
    localparam logic [8:0] V_VSYNC_START = 9'd244;
    localparam logic [8:0] V_VSYNC_END   = 9'd247;

    // Inclusive range test on a 9-bit counter value
    function automatic logic inRange(input logic [8:0] v,
                                     input logic [8:0] lo,
                                     input logic [8:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/ppu_pixel_clock.sv
// ---------------------------------------------------------------------------
// ppu_pixel_clock
//
// Divides the master clock into the PPU pixel clock.
//
// Ports:
//   clk_i    in   master clock
//   rst_i    in   synchronous active-high reset
//   tick_o   out  pixel tick: high during the master cycle whose rising edge
//                 advances the dot/line counters (phase 0 of each pixel)
//   pclk_o   out  pixel clock, high for the first CLK_DIV/2 master cycles
//   nPclk_o  out  inverse of pclk_o
//
// The phase register counts 0..CLK_DIV-1. Reset parks it at 0, so the very
// first edge after reset release is a pixel tick; PCLK is registered from
// the phase being left, which makes its rising edge land on the same master
// edge as the counter update.
// ---------------------------------------------------------------------------
module ppu_pixel_clock #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o,
    output logic pclk_o,
    output logic nPclk_o
);

    localparam int PHASE_W = $clog2(CLK_DIV);
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CLK_DIV - 1);
    localparam logic [PHASE_W-1:0] PHASE_HIGH = PHASE_W'(CLK_DIV / 2);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               pclk_q, pclk_d;

    // Next phase wraps after the last master cycle of a pixel; PCLK is high
    // for the phases below the half-way point of the phase being left
    always_comb begin
        phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
        pclk_d  = (phase_q < PHASE_HIGH);
    end

    // Phase and PCLK registers; reset wins over any phase position
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
            pclk_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            pclk_q  <= pclk_d;
        end
    end

    assign tick_o  = (phase_q == '0);
    assign pclk_o  = pclk_q;
    assign nPclk_o = ~pclk_q;

endmodule

// File: rtl/ppu_hv_timing.sv
// ---------------------------------------------------------------------------
// ppu_hv_timing
//
// PPU raster timing core: pixel-clock divider, dot and scanline counters,
// and the horizontal / vertical decode PLAs consumed by the video
// generator, fetch and OAM logic.
//
// Ports:
//   CLK       in   master clock, all state on the rising edge
//   RES       in   synchronous active-high reset
//   VB        in   vertical-blank qualifier for VPLA terms 7 and 9
//   BLNK      in   rendering disabled; forces the fetch-window HPLA terms low
//   PCLK      out  pixel clock
//   n_PCLK    out  inverse of PCLK
//   H_out     out  dot counter, 0..H_LAST
//   V_out     out  line counter, 0..V_LAST
//   HC        out  end of line (H == H_LAST)
//   VC        out  end of frame (V == V_LAST on the last dot)
//   V_IN      out  line increment strobe
//   HPLA_out  out  24 horizontal decode strobes
//   VPLA_out  out  10 vertical decode strobes
//
// Decode dot/line numbers are NTSC values regardless of H_LAST/V_LAST; only
// the clear logic and the V_LAST-relative VPLA terms follow the parameters.
// ---------------------------------------------------------------------------
module ppu_hv_timing
    import ppu_timing_pkg::*;
#(
    parameter int CLK_DIV = NTSC_CLK_DIV,
    parameter int H_LAST  = NTSC_H_LAST,
    parameter int V_LAST  = NTSC_V_LAST
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        VB,
    input  logic        BLNK,
    output logic        PCLK,
    output logic        n_PCLK,
    output logic [8:0]  H_out,
    output logic [8:0]  V_out,
    output logic        HC,
    output logic        VC,
    output logic        V_IN,
    output logic [23:0] HPLA_out,
    output logic [9:0]  VPLA_out
);

    localparam logic [8:0] H_LAST_C = 9'(H_LAST);
    localparam logic [8:0] V_LAST_C = 9'(V_LAST);

    logic       pixTick;
    logic [8:0] hCnt_q, hCnt_d;
    logic [8:0] vCnt_q, vCnt_d;
    logic       hClear, vClear, vInc;
    logic       fetchEn;
    logic [HPLA_W-1:0] hpla;
    logic [VPLA_W-1:0] vpla;

    ppu_pixel_clock #(
        .CLK_DIV (CLK_DIV)
    ) u_pixClk (
        .clk_i   (CLK),
        .rst_i   (RES),
        .tick_o  (pixTick),
        .pclk_o  (PCLK),
        .nPclk_o (n_PCLK)
    );

    assign hClear = (hCnt_q == H_LAST_C);
    assign vInc   = hClear;
    assign vClear = (vCnt_q == V_LAST_C) && hClear;

    // Counter next-state: nothing moves between pixel ticks. Out-of-range
    // values from a mis-parameterised build simply roll through the 9-bit
    // adder until the clear compare catches them.
    always_comb begin
        hCnt_d = hCnt_q;
        vCnt_d = vCnt_q;
        if (pixTick) begin
            hCnt_d = hClear ? '0 : hCnt_q + 9'd1;
            if (vClear) begin
                vCnt_d = '0;
            end else if (vInc) begin
                vCnt_d = vCnt_q + 9'd1;
            end
        end
    end

    // Dot and line counter registers
    always_ff @(posedge CLK) begin
        if (RES) begin
            hCnt_q <= '0;
            vCnt_q <= '0;
        end else begin
            hCnt_q <= hCnt_d;
            vCnt_q <= vCnt_d;
        end
    end

    assign fetchEn = ~BLNK;

    // Horizontal PLA; fetch-window terms are suppressed while blanked
    always_comb begin
        hpla = '0;
        hpla[HPLA_H279]         = (hCnt_q == H_279);
        hpla[HPLA_H256]         = (hCnt_q == H_256);
        hpla[HPLA_H65]          = (hCnt_q == H_65);
        hpla[HPLA_FETCH_BG]     = fetchEn && inRange(hCnt_q, H_0, H_255);
        hpla[HPLA_FETCH_0_63]   = fetchEn && inRange(hCnt_q, H_0, H_63);
        hpla[HPLA_FETCH_64_255] = fetchEn && inRange(hCnt_q, H_64, H_255);
        hpla[HPLA_FETCH_SPR]    = fetchEn && inRange(hCnt_q, H_256, H_319);
        hpla[HPLA_FETCH_PRE]    = fetchEn && inRange(hCnt_q, H_320, H_335);
        hpla[HPLA_DUMMY]        = inRange(hCnt_q, H_336, H_339);
        hpla[HPLA_H63]          = (hCnt_q == H_63);
        hpla[HPLA_H255]         = (hCnt_q == H_255);
        hpla[HPLA_H339]         = (hCnt_q == H_339);
        hpla[HPLA_BURST_START]  = (hCnt_q == H_BURST_START);
        hpla[HPLA_BURST_END]    = (hCnt_q == H_BURST_END);
        hpla[HPLA_H0_7]         = inRange(hCnt_q, H_0, H_7);
        hpla[HPLA_H8_255]       = inRange(hCnt_q, H_8, H_255);
        // Once per 8-dot tile, only inside the two tile-fetch windows
        hpla[HPLA_TILE_STROBE]  = fetchEn && (hCnt_q[2:0] == 3'd0) &&
                                  (inRange(hCnt_q, H_0, H_255) ||
                                   inRange(hCnt_q, H_320, H_335));
        hpla[HPLA_H320]         = (hCnt_q == H_320);
        hpla[HPLA_H328]         = (hCnt_q == H_328);
        hpla[HPLA_FPORCH_END]   = (hCnt_q == H_FPORCH_END);
        hpla[HPLA_HSYNC]        = inRange(hCnt_q, H_279, H_HSYNC_END);
        hpla[HPLA_HBLANK]       = inRange(hCnt_q, H_256, H_340);
        hpla[HPLA_H0]           = (hCnt_q == H_0);
        hpla[HPLA_H340]         = (hCnt_q == H_340);
    end

    // Vertical PLA; the blanking-interval terms end one line before V_LAST
    always_comb begin
        vpla = '0;
        vpla[VPLA_V240]        = (vCnt_q == V_240);
        vpla[VPLA_VBL_SET]     = (vCnt_q == V_VBL_SET);
        vpla[VPLA_VLAST]       = (vCnt_q == V_LAST_C);
        vpla[VPLA_VISIBLE]     = inRange(vCnt_q, V_0, V_239);
        vpla[VPLA_VSYNC_START] = (vCnt_q == V_VSYNC_START);
        vpla[VPLA_VSYNC_END]   = (vCnt_q == V_VSYNC_END);
        vpla[VPLA_V0]          = (vCnt_q == V_0);
        vpla[VPLA_VLAST_VB]    = (vCnt_q == V_LAST_C) && VB;
        vpla[VPLA_VBLANK]      = (vCnt_q >= V_240) && (vCnt_q < V_LAST_C);
        vpla[VPLA_VBL_VB]      = (vCnt_q >= V_VBL_SET) && (vCnt_q < V_LAST_C) && VB;
    end

    assign H_out    = hCnt_q;
    assign V_out    = vCnt_q;
    assign HC       = hClear;
    assign VC       = vClear;
    assign V_IN     = vInc;
    assign HPLA_out = hpla;
    assign VPLA_out = vpla;

endmodule

// File: tb/tb_ppu_hv_timing.sv
// ---------------------------------------------------------------------------
// tb_ppu_hv_timing
//
// Three instances share CLK/RES/VB/BLNK:
//   dut     default NTSC timing (CLK_DIV=4, 341 dots, 262 lines)
//   dut5    CLK_DIV=5 for the PAL-rate pixel clock shape
//   dutFast CLK_DIV=2 with a 16-dot line so frame-end behaviour is reachable
//           in a short run (decode constants are fixed, so VPLA is unchanged)
// Expected values are pushed into a queue by the stimulus; a monitor pops
// and compares whenever the stimulus raises the sample event.
// ---------------------------------------------------------------------------
module tb_ppu_hv_timing;

    logic CLK = 1'b0;
    logic RES, VB, BLNK;

    logic        mPclk, mNPclk, mHc, mVc, mVin;
    logic [8:0]  mH, mV;
    logic [23:0] mHpla;
    logic [9:0]  mVpla;

    logic        pPclk, pNPclk, pHc, pVc, pVin;
    logic [8:0]  pH, pV;
    logic [23:0] pHpla;
    logic [9:0]  pVpla;

    logic        fPclk, fNPclk, fHc, fVc, fVin;
    logic [8:0]  fH, fV;
    logic [23:0] fHpla;
    logic [9:0]  fVpla;

    localparam int M_PCLK = 0,  M_NPCLK = 1,  M_H = 2,  M_V = 3,  M_HC = 4;
    localparam int M_VC = 5,    M_VIN = 6,    M_HPLA = 7, M_VPLA = 8;
    localparam int M_HPLA23 = 9, M_HPLA11 = 10;
    localparam int P_PCLK = 11, P_NPCLK = 12, P_H = 13, P_MISC = 14;
    localparam int F_PCLK = 15, F_H = 16, F_V = 17, F_VC = 18, F_VPLA = 19;
    localparam int F_HC = 20,   F_MISC = 21;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } expItem_t;

    expItem_t expQ[$];
    event     sampleEv;
    int       errors = 0;
    int       checks = 0;
    int       edges  = 0;

    ppu_hv_timing dut (
        .CLK(CLK), .RES(RES), .VB(VB), .BLNK(BLNK),
        .PCLK(mPclk), .n_PCLK(mNPclk), .H_out(mH), .V_out(mV),
        .HC(mHc), .VC(mVc), .V_IN(mVin), .HPLA_out(mHpla), .VPLA_out(mVpla)
    );

    ppu_hv_timing #(.CLK_DIV(5), .H_LAST(340), .V_LAST(311)) dut5 (
        .CLK(CLK), .RES(RES), .VB(VB), .BLNK(BLNK),
        .PCLK(pPclk), .n_PCLK(pNPclk), .H_out(pH), .V_out(pV),
        .HC(pHc), .VC(pVc), .V_IN(pVin), .HPLA_out(pHpla), .VPLA_out(pVpla)
    );

    ppu_hv_timing #(.CLK_DIV(2), .H_LAST(15), .V_LAST(261)) dutFast (
        .CLK(CLK), .RES(RES), .VB(VB), .BLNK(BLNK),
        .PCLK(fPclk), .n_PCLK(fNPclk), .H_out(fH), .V_out(fV),
        .HC(fHc), .VC(fVc), .V_IN(fVin), .HPLA_out(fHpla), .VPLA_out(fVpla)
    );

    always #5 CLK = ~CLK;

    // Select the DUT output a queued expectation refers to
    function automatic logic [31:0] getField(input int sel);
        logic [31:0] r;
        r = '0;
        case (sel)
            M_PCLK:   r = 32'(mPclk);
            M_NPCLK:  r = 32'(mNPclk);
            M_H:      r = 32'(mH);
            M_V:      r = 32'(mV);
            M_HC:     r = 32'(mHc);
            M_VC:     r = 32'(mVc);
            M_VIN:    r = 32'(mVin);
            M_HPLA:   r = 32'(mHpla);
            M_VPLA:   r = 32'(mVpla);
            M_HPLA23: r = 32'(mHpla[23]);
            M_HPLA11: r = 32'(mHpla[11]);
            P_PCLK:   r = 32'(pPclk);
            P_NPCLK:  r = 32'(pNPclk);
            P_H:      r = 32'(pH);
            P_MISC:   r = {pV[2:0], pHc, pVc, pVin, pHpla[15:0], pVpla};
            F_PCLK:   r = 32'(fPclk);
            F_H:      r = 32'(fH);
            F_V:      r = 32'(fV);
            F_VC:     r = 32'(fVc);
            F_VPLA:   r = 32'(fVpla);
            F_HC:     r = 32'(fHc);
            F_MISC:   r = {7'd0, fNPclk, fVin, fHpla};
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Monitor: drain every pending expectation at each sample point
    initial begin
        forever begin
            expItem_t it;
            @(sampleEv);
            while (expQ.size() > 0) begin
                it = expQ.pop_front();
                checks++;
                if (getField(it.sel) !== it.exp) begin
                    errors++;
                    $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                             it.name, getField(it.sel), it.exp, $time);
                end
            end
        end
    end

    initial begin
        #10000000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n master clock edges, landing 1 time unit after the last edge
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge CLK);
            edges++;
        end
        #1;
    endtask

    task automatic checkOutput(input string name, input int sel, input logic [31:0] exp);
        expItem_t it;
        it.name = name;
        it.sel  = sel;
        it.exp  = exp;
        expQ.push_back(it);
    endtask

    task automatic sampleNow();
        -> sampleEv;
        #1;
    endtask

    // Reference timing: ticks fall on edges 1, 1+CLK_DIV, ... after release
    function automatic int mainTicks();  return (edges + 3) / 4;              endfunction
    function automatic int mainH();      return mainTicks() % 341;            endfunction
    function automatic int mainV();      return (mainTicks() / 341) % 262;    endfunction
    function automatic int fastTicks();  return (edges + 1) / 2;              endfunction

    int pclkPat4 [8]  = '{1, 1, 0, 0, 1, 1, 0, 0};
    int hPat4    [8]  = '{1, 1, 1, 1, 2, 2, 2, 2};
    int pclkPat5 [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
    int hPat5    [10] = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 2};
    int pclkPat2 [4]  = '{1, 0, 1, 0};

    int          hTgt [14] = '{255, 256, 270, 279, 309, 320, 324, 328, 336, 339, 340, 0, 63, 65};
    logic [23:0] hVec [14] = '{24'h008428, 24'h200042, 24'h280040, 24'h300041,
                               24'h201040, 24'h230080, 24'h202080, 24'h250080,
                               24'h200100, 24'h200900, 24'hA00000, 24'h414018,
                               24'h008218, 24'h00802C};

    int          fTgt [8] = '{240*16, 241*16, 244*16, 247*16, 250*16, 250*16,
                              261*16+15, 261*16+15};
    logic        fVb  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [9:0]  fVec [8] = '{10'h101, 10'h302, 10'h110, 10'h120,
                              10'h100, 10'h300, 10'h004, 10'h084};
    logic        fVcE [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int h, v, d;
        RES  = 1'b1;
        VB   = 1'b0;
        BLNK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset state
        checkOutput("rst_pclk",  M_PCLK,  32'd0);
        checkOutput("rst_npclk", M_NPCLK, 32'd1);
        checkOutput("rst_h",     M_H,     32'd0);
        checkOutput("rst_v",     M_V,     32'd0);
        checkOutput("rst_hc",    M_HC,    32'd0);
        checkOutput("rst_vc",    M_VC,    32'd0);
        checkOutput("rst_hpla",  M_HPLA,  32'h414018);
        checkOutput("rst_vpla",  M_VPLA,  32'h48);
        checkOutput("rst_p5pclk", P_PCLK, 32'd0);
        checkOutput("rst_fh",    F_H,     32'd0);
        sampleNow();
        RES   = 1'b0;
        edges = 0;

        // PCLK shape and first H steps
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1);
            checkOutput("pclk_pat",  M_PCLK,  32'(pclkPat4[k]));
            checkOutput("npclk_pat", M_NPCLK, 32'(1 - pclkPat4[k]));
            checkOutput("h_step",    M_H,     32'(hPat4[k]));
            sampleNow();
        end

        // One full line: H wraps 340 -> 0 and V increments on that tick
        for (int i = 0; i < 341; i++) begin
            applyStimulus(4);
            h = mainH();
            v = mainV();
            checkOutput("line_h",      M_H,      32'(h));
            checkOutput("line_v",      M_V,      32'(v));
            checkOutput("line_hc",     M_HC,     32'(h == 340));
            checkOutput("line_vin",    M_VIN,    32'(h == 340));
            checkOutput("line_hpla23", M_HPLA23, 32'(h == 340));
            checkOutput("line_hpla11", M_HPLA11, 32'(h == 339));
            sampleNow();
        end

        // BLNK gating of fetch windows at H=100
        d = (100 - mainH() + 341) % 341;
        applyStimulus(4 * d);
        checkOutput("blnk_h100", M_H, 32'd100);
        BLNK = 1'b1;
        checkOutput("blnk1_hpla", M_HPLA, 32'h008000);
        sampleNow();
        BLNK = 1'b0;
        checkOutput("blnk0_hpla", M_HPLA, 32'h008028);
        sampleNow();

        // HPLA decode at the event dots
        for (int i = 0; i < 14; i++) begin
            d = (hTgt[i] - mainH() + 341) % 341;
            applyStimulus(4 * d);
            checkOutput("hpla_h",   M_H,    32'(hTgt[i]));
            checkOutput("hpla_vec", M_HPLA, 32'(hVec[i]));
            sampleNow();
            if (hTgt[i] == 0) begin
                BLNK = 1'b1;
                checkOutput("hpla_h0_blnk", M_HPLA, 32'h404000);
                sampleNow();
                BLNK = 1'b0;
            end
        end

        // VPLA and frame end on the short-line instance
        for (int i = 0; i < 8; i++) begin
            VB = fVb[i];
            d = (fTgt[i] - (fastTicks() % 4192) + 4192) % 4192;
            applyStimulus(2 * d);
            checkOutput("vpla_v",   F_V,    32'(fTgt[i] / 16));
            checkOutput("vpla_h",   F_H,    32'(fTgt[i] % 16));
            checkOutput("vpla_vec", F_VPLA, 32'(fVec[i]));
            checkOutput("vpla_vc",  F_VC,   32'(fVcE[i]));
            sampleNow();
        end
        checkOutput("frame_end_hc", F_HC, 32'd1);
        sampleNow();
        VB = 1'b0;
        applyStimulus(2);
        checkOutput("wrap_h",    F_H,    32'd0);
        checkOutput("wrap_v",    F_V,    32'd0);
        checkOutput("wrap_vc",   F_VC,   32'd0);
        checkOutput("wrap_vpla", F_VPLA, 32'h48);
        sampleNow();

        // Mid-frame reset at H=123 while PCLK is high
        applyStimulus((4 - edges % 4) % 4);
        d = (123 - mainH() + 341) % 341;
        if (d == 0) d = 341;
        applyStimulus(4 * (d - 1) + 1);
        checkOutput("pre_res_h",    M_H,    32'd123);
        checkOutput("pre_res_pclk", M_PCLK, 32'd1);
        sampleNow();
        RES = 1'b1;
        applyStimulus(1);
        checkOutput("res_h",     M_H,     32'd0);
        checkOutput("res_v",     M_V,     32'd0);
        checkOutput("res_pclk",  M_PCLK,  32'd0);
        checkOutput("res_npclk", M_NPCLK, 32'd1);
        checkOutput("res_p5h",   P_H,     32'd0);
        checkOutput("res_fv",    F_V,     32'd0);
        sampleNow();
        RES   = 1'b0;
        edges = 0;

        // CLK_DIV=5: PCLK high 2, low 3; CLK_DIV=2: alternating
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1);
            checkOutput("p5_pclk",  P_PCLK,  32'(pclkPat5[k]));
            checkOutput("p5_npclk", P_NPCLK, 32'(1 - pclkPat5[k]));
            checkOutput("p5_h",     P_H,     32'(hPat5[k]));
            if (k < 4) checkOutput("p2_pclk", F_PCLK, 32'(pclkPat2[k]));
            sampleNow();
        end
        checkOutput("post_res_h", M_H, 32'(mainH()));
        sampleNow();

        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
